agu_operand_stage: RTL and testbench

- Pipeline stage directly upstream of the execute-stage three-input carry-save adder.
- Forms the adder operands A, B, C and CIN from decoded address-generation fields: base, scaled index, sign-extended displacement.
- Registers the operands behind a valid/ready handshake with a 2-entry skid buffer, so the adder stage can stall without losing operands.

---
 rtl/agu_operand_stage_if.sv | 35 +++
 rtl/agu_operand_stage.sv | 129 ++++++++++++
 tb/tb_agu_operand_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/agu_operand_stage_if.sv
// Handshake and operand bus between the address-generation decoder, this stage and the adder.
// The stage takes the slave view; the upstream/downstream environment takes the master view.
interface agu_operand_stage_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] base;
  logic         base_en;
  logic [W-1:0] index;
  logic         index_en;
  logic [1:0]   scale;
  logic [W-1:0] disp;
  logic [1:0]   disp_size;
  logic         addr16;
  logic         cin_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         CIN;

  modport master (
    output in_valid, base, base_en, index, index_en, scale,
           disp, disp_size, addr16, cin_in, out_ready,
    input  in_ready, out_valid, A, B, C, CIN
  );

  modport slave (
    input  in_valid, base, base_en, index, index_en, scale,
           disp, disp_size, addr16, cin_in, out_ready,
    output in_ready, out_valid, A, B, C, CIN
  );
endinterface

// File: rtl/agu_operand_stage.sv
// Forms carry-save adder operands (base, scaled index, extended displacement, carry-in)
// and registers them behind a valid/ready handshake with a 2-entry skid buffer.
module agu_operand_stage #(
  parameter int unsigned W       = 32,
  parameter int unsigned DISP8_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  agu_operand_stage_if.slave    bus
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         cin;
  } opnd_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [W-1:0] LO16_MASK = {{(W-16){1'b0}}, {16{1'b1}}};

  state_t state_q, state_d;
  opnd_t  out_q, out_d;
  opnd_t  skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;

  opnd_t        new_op;
  logic [W-1:0] base_m;
  logic [W-1:0] idx_m;
  logic [W-1:0] idx_sh;
  logic [W-1:0] disp_x;
  logic         accept;
  logic         drain;

  // Operand formation; masking after the shift is equivalent to truncating before and after.
  always_comb begin
    base_m = bus.base_en  ? bus.base  : '0;
    idx_m  = bus.index_en ? bus.index : '0;
    idx_sh = idx_m << bus.scale;
    case (bus.disp_size)
      2'd0:    disp_x = '0;
      2'd1:    disp_x = {{(W-DISP8_W){bus.disp[DISP8_W-1]}}, bus.disp[DISP8_W-1:0]};
      2'd2:    disp_x = {{(W-16){bus.disp[15]}}, bus.disp[15:0]};
      default: disp_x = bus.disp;
    endcase
    new_op.a   = base_m;
    new_op.b   = idx_sh;
    new_op.c   = disp_x;
    new_op.cin = bus.cin_in;
    if (bus.addr16) begin
      new_op.a = base_m & LO16_MASK;
      new_op.b = idx_sh & LO16_MASK;
      new_op.c = disp_x & LO16_MASK;
    end
  end

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          out_d   = new_op;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          out_d = new_op;
        end else if (accept) begin
          skid_d  = new_op;
          state_d = S_FULL;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush discards any same-cycle accept; only the valid state is cleared.
    if (flush) begin
      state_d = S_EMPTY;
      out_d   = out_q;
      skid_d  = skid_q;
    end
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.A         = out_q.a;
  assign bus.B         = out_q.b;
  assign bus.C         = out_q.c;
  assign bus.CIN       = out_q.cin;

endmodule

// File: tb/tb_agu_operand_stage.sv
// Directed self-checking bench for agu_operand_stage with hand-computed expectations.
module tb_agu_operand_stage;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fail;

  agu_operand_stage_if #(.W(W)) bus ();

  agu_operand_stage #(.W(W), .DISP8_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [W-1:0] b, input logic ben, input logic [W-1:0] i,
                         input logic ien, input logic [1:0] sc, input logic [W-1:0] d,
                         input logic [1:0] ds, input logic a16, input logic ci);
    bus.base      = b;
    bus.base_en   = ben;
    bus.index     = i;
    bus.index_en  = ien;
    bus.scale     = sc;
    bus.disp      = d;
    bus.disp_size = ds;
    bus.addr16    = a16;
    bus.cin_in    = ci;
  endtask

  task automatic check_ops(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic ci);
    check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, ".A"}, bus.A, a);
    check({tag, ".B"}, bus.B, b);
    check({tag, ".C"}, bus.C, c);
    check({tag, ".CIN"}, {31'd0, bus.CIN}, {31'd0, ci});
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, ".A"}, bus.A, 32'd0);
    check({tag, ".B"}, bus.B, 32'd0);
    check({tag, ".C"}, bus.C, 32'd0);
    check({tag, ".CIN"}, {31'd0, bus.CIN}, 32'd0);
  endtask

  task automatic scenario1(input string tag);
    set_req(32'h1000, 1'b1, 32'h10, 1'b1, 2'd2, 32'hFC, 2'd1, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_ops(tag, 32'h1000, 32'h40, 32'hFFFF_FFFC, 1'b0);
    check({tag, ".sum"}, bus.A + bus.B + bus.C + {31'd0, bus.CIN}, 32'h103C);
    step();
    check({tag, ".drained"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic ci);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_ops(tag, a, b, c, ci);
    step();
  endtask

  task automatic fill_full();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_req(32'h111, 1'b1, 32'h1, 1'b1, 2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    set_req(32'h222, 1'b1, 32'h2, 1'b1, 2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req('0, 1'b0, '0, 1'b0, 2'd0, '0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    check_reset("reset");
    rst = 1'b1;
    step();

    scenario1("s1");

    set_req(32'h1234_FFF0, 1'b1, 32'hABCD_0008, 1'b1, 2'd1, 32'h0020, 2'd2, 1'b1, 1'b0);
    single("s2_addr16", 32'h0000_FFF0, 32'h0000_0010, 32'h0000_0020, 1'b0);

    set_req(32'hDEAD, 1'b0, 32'hBEEF, 1'b0, 2'd3, 32'h55, 2'd0, 1'b0, 1'b1);
    single("s4_masked", 32'h0, 32'h0, 32'h0, 1'b1);

    set_req(32'hFFFF_FFFF, 1'b1, 32'hF000_0001, 1'b1, 2'd3, 32'h1234_5678, 2'd3, 1'b0, 1'b0);
    single("shift_overflow", 32'hFFFF_FFFF, 32'h8000_0008, 32'h1234_5678, 1'b0);

    set_req(32'h0, 1'b1, 32'h0, 1'b1, 2'd0, 32'hAAAA_8000, 2'd2, 1'b0, 1'b0);
    single("sext16_neg", 32'h0, 32'h0, 32'hFFFF_8000, 1'b0);

    set_req(32'h0, 1'b1, 32'h0, 1'b1, 2'd0, 32'h0000_0080, 2'd1, 1'b1, 1'b1);
    single("sext8_addr16", 32'h0, 32'h0, 32'h0000_FF80, 1'b1);

    // Scenario 3: stall for two cycles, third request held upstream.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_req(32'h111, 1'b1, 32'h1, 1'b1, 2'd1, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    check("s3.ready_after1", {31'd0, bus.in_ready}, 32'd1);
    check("s3.A_r1", bus.A, 32'h111);
    set_req(32'h222, 1'b1, 32'h2, 1'b1, 2'd1, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    check("s3.ready_after2", {31'd0, bus.in_ready}, 32'd0);
    check("s3.A_hold1", bus.A, 32'h111);
    set_req(32'h333, 1'b1, 32'h3, 1'b1, 2'd1, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    check("s3.ready_held", {31'd0, bus.in_ready}, 32'd0);
    check("s3.A_hold2", bus.A, 32'h111);
    check("s3.B_hold2", bus.B, 32'h2);
    bus.out_ready = 1'b1;
    step();
    check_ops("s3.r2", 32'h222, 32'h4, 32'h0, 1'b0);
    check("s3.ready_reopen", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    check_ops("s3.r3", 32'h333, 32'h6, 32'h0, 1'b1);
    step();
    check("s3.empty", {31'd0, bus.out_valid}, 32'd0);

    // Scenario 5: flush while FULL with a competing request.
    fill_full();
    check("s5.full", {31'd0, bus.in_ready}, 32'd0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    set_req(32'h999, 1'b1, 32'h9, 1'b1, 2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("s5.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("s5.in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("s5.not_captured", {31'd0, bus.out_valid}, 32'd0);

    // Scenario 6: reset while FULL with out_ready toggling and a request pending.
    fill_full();
    bus.out_ready = 1'b1;
    step();
    check("s6.pre_A", bus.A, 32'h222);
    bus.out_ready = 1'b0;
    set_req(32'h444, 1'b1, 32'h4, 1'b1, 2'd0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_reset("s6.reset");
    rst = 1'b1;
    step();
    scenario1("s6.post");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
